// File: rtl/loop_replay_reader_pkg.sv
// Shared loop-buffer definitions used by both the loop detector (writer)
// and the replay reader.
//   state_t      : reader FSM encoding (IDLE=0, FILL=1, REPLAY=2, EXIT=3)
//   NOP_INSTR    : instruction word shown whenever no replay entry is valid
//   XLEN_DEFAULT : default PC / instruction width
package loop_replay_reader_pkg;

    localparam int          XLEN_DEFAULT = 32;
    localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        REPLAY = 2'd2,
        EXIT   = 2'd3
    } state_t;

endpackage

// File: rtl/loop_body_mem.sv
// Loop-body storage: DEPTH x W register array.
//   clk   : rising-edge clock
//   we    : write enable, one entry per cycle
//   waddr : write slot
//   wdata : packed {pc, instruction}
//   raddr : read slot (asynchronous read)
//   rdata : contents of slot raddr
// Contents are not reset; the reader only reads slots it has written.
module loop_body_mem #(
    parameter int DEPTH = 8,
    parameter int W     = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/loop_replay_reader.sv
// Read side of the loop buffer. Captures a loop body pushed by the loop
// detector, replays it cyclically into IF/ID while fetch is blocked, and on
// a loop-exit mispredict flushes and redirects fetch to the fall-through PC.
//   clk, reset       : clock, synchronous active-low reset
//   wr_valid/wr_pc/wr_instr/wr_last/wr_ready : body write handshake
//   bubble_idex      : downstream stall, holds the replay output
//   mispredict       : loop exit resolved, ends replay
//   active           : replay in progress (fetch blocked)
//   out_valid/out_pc/out_instruction : replayed entry (NOP when invalid)
//   flush/new_pc     : one-cycle redirect at replay exit
//   overflow         : one-cycle pulse when a body longer than DEPTH is dropped
//   state            : current FSM state, for debug and checkers
//
// Handshake: an entry transfers on every rising edge where wr_valid and
// wr_ready are both 1; the writer holds wr_valid and its data until then.
module loop_replay_reader
    import loop_replay_reader_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int XLEN  = XLEN_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            wr_valid,
    input  logic [XLEN-1:0] wr_pc,
    input  logic [XLEN-1:0] wr_instr,
    input  logic            wr_last,
    output logic            wr_ready,
    input  logic            bubble_idex,
    input  logic            mispredict,
    output logic            active,
    output logic            out_valid,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_instruction,
    output logic            flush,
    output logic [XLEN-1:0] new_pc,
    output logic            overflow,
    output state_t          state
);

    localparam int AW = $clog2(DEPTH);

    state_t          state_q, state_next;
    logic [AW-1:0]   wr_cnt_q, wr_cnt_next;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_next;
    logic [AW:0]     len_q, len_next;
    logic [XLEN-1:0] last_pc_q, last_pc_next;

    logic            wr_ready_next, active_next, out_valid_next;
    logic            flush_next, overflow_next;
    logic [XLEN-1:0] out_pc_next, out_instr_next, new_pc_next;

    logic              accept, mem_we, load_from_wr, load_from_mem;
    logic [2*XLEN-1:0] rdata;

    loop_body_mem #(
        .DEPTH (DEPTH),
        .W     (2 * XLEN),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (wr_cnt_q),
        .wdata ({wr_pc, wr_instr}),
        .raddr (rd_ptr_next),
        .rdata (rdata)
    );

    always_comb begin
        state_next     = state_q;
        wr_cnt_next    = wr_cnt_q;
        rd_ptr_next    = rd_ptr_q;
        len_next       = len_q;
        last_pc_next   = last_pc_q;
        flush_next     = 1'b0;
        new_pc_next    = '0;
        overflow_next  = 1'b0;
        mem_we         = 1'b0;
        load_from_wr   = 1'b0;
        load_from_mem  = 1'b0;
        accept         = wr_valid & wr_ready;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    mem_we       = 1'b1;
                    len_next     = (AW+1)'(1);
                    last_pc_next = wr_pc;
                    if (wr_last) begin
                        // Single-entry loop: slot 0 is written this very
                        // edge, so show the write data instead of memory.
                        state_next   = REPLAY;
                        wr_cnt_next  = '0;
                        rd_ptr_next  = '0;
                        load_from_wr = 1'b1;
                    end else begin
                        state_next  = FILL;
                        wr_cnt_next = AW'(1);
                    end
                end
            end
            FILL: begin
                if (mispredict) begin
                    state_next  = IDLE;
                    wr_cnt_next = '0;
                end else if (accept) begin
                    mem_we = 1'b1;
                    if (wr_last) begin
                        state_next    = REPLAY;
                        len_next      = {1'b0, wr_cnt_q} + (AW+1)'(1);
                        last_pc_next  = wr_pc;
                        wr_cnt_next   = '0;
                        rd_ptr_next   = '0;
                        load_from_mem = 1'b1;
                    end else if (wr_cnt_q == AW'(DEPTH - 1)) begin
                        state_next    = IDLE;
                        wr_cnt_next   = '0;
                        overflow_next = 1'b1;
                    end else begin
                        wr_cnt_next = wr_cnt_q + AW'(1);
                    end
                end
            end
            REPLAY: begin
                if (mispredict) begin
                    state_next  = EXIT;
                    flush_next  = 1'b1;
                    new_pc_next = last_pc_q + XLEN'(4);
                end else begin
                    // A stall re-reads the same slot, which holds the output.
                    load_from_mem = 1'b1;
                    if (!bubble_idex) begin
                        rd_ptr_next = ({1'b0, rd_ptr_q} == len_q - (AW+1)'(1))
                                      ? '0 : rd_ptr_q + AW'(1);
                    end
                end
            end
            EXIT: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        out_valid_next = 1'b0;
        out_pc_next    = '0;
        out_instr_next = XLEN'(NOP_INSTR);
        if (load_from_wr) begin
            out_valid_next = 1'b1;
            out_pc_next    = wr_pc;
            out_instr_next = wr_instr;
        end else if (load_from_mem) begin
            out_valid_next = 1'b1;
            out_pc_next    = rdata[2*XLEN-1:XLEN];
            out_instr_next = rdata[XLEN-1:0];
        end

        wr_ready_next = (state_next == IDLE) || (state_next == FILL);
        active_next   = (state_next == REPLAY) || (state_next == EXIT);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q         <= IDLE;
            wr_cnt_q        <= '0;
            rd_ptr_q        <= '0;
            len_q           <= '0;
            last_pc_q       <= '0;
            wr_ready        <= 1'b1;
            active          <= 1'b0;
            out_valid       <= 1'b0;
            out_pc          <= '0;
            out_instruction <= XLEN'(NOP_INSTR);
            flush           <= 1'b0;
            new_pc          <= '0;
            overflow        <= 1'b0;
        end else begin
            state_q         <= state_next;
            wr_cnt_q        <= wr_cnt_next;
            rd_ptr_q        <= rd_ptr_next;
            len_q           <= len_next;
            last_pc_q       <= last_pc_next;
            wr_ready        <= wr_ready_next;
            active          <= active_next;
            out_valid       <= out_valid_next;
            out_pc          <= out_pc_next;
            out_instruction <= out_instr_next;
            flush           <= flush_next;
            new_pc          <= new_pc_next;
            overflow        <= overflow_next;
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_loop_replay_reader.sv
module tb_loop_replay_reader;
    import loop_replay_reader_pkg::*;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            wr_valid = 1'b0;
    logic [XLEN-1:0] wr_pc = '0;
    logic [XLEN-1:0] wr_instr = '0;
    logic            wr_last = 1'b0;
    logic            wr_ready;
    logic            bubble_idex = 1'b0;
    logic            mispredict = 1'b0;
    logic            active;
    logic            out_valid;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_instruction;
    logic            flush;
    logic [XLEN-1:0] new_pc;
    logic            overflow;
    state_t          state;

    int n_checks = 0;
    int n_pass   = 0;

    logic [XLEN-1:0] exp_q[$];

    loop_replay_reader #(.DEPTH(8), .XLEN(XLEN)) dut (
        .clk             (clk),
        .reset           (reset),
        .wr_valid        (wr_valid),
        .wr_pc           (wr_pc),
        .wr_instr        (wr_instr),
        .wr_last         (wr_last),
        .wr_ready        (wr_ready),
        .bubble_idex     (bubble_idex),
        .mispredict      (mispredict),
        .active          (active),
        .out_valid       (out_valid),
        .out_pc          (out_pc),
        .out_instruction (out_instruction),
        .flush           (flush),
        .new_pc          (new_pc),
        .overflow        (overflow),
        .state           (state)
    );

    // clock / reset
    always #5 clk = ~clk;

    // Advance one rising edge; outputs are then sampled 1ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // driver tasks
    task automatic write_entry(input logic [31:0] pc, input logic [31:0] instr, input logic last);
        wr_valid = 1'b1;
        wr_pc    = pc;
        wr_instr = instr;
        wr_last  = last;
        tick();
        wr_valid = 1'b0;
        wr_last  = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, ".wr_ready"},  32'(wr_ready), 32'd1);
        check({tag, ".active"},    32'(active), 32'd0);
        check({tag, ".out_valid"}, 32'(out_valid), 32'd0);
        check({tag, ".out_pc"},    out_pc, 32'h0);
        check({tag, ".out_instr"}, out_instruction, 32'h0000_0013);
        check({tag, ".flush"},     32'(flush), 32'd0);
        check({tag, ".new_pc"},    new_pc, 32'h0);
        check({tag, ".overflow"},  32'(overflow), 32'd0);
        check({tag, ".state"},     32'(state), 32'd0);
    endtask

    // scoreboard: compare current out_pc with the head of exp_q, then step
    task automatic drain_replay(input string tag);
        logic [XLEN-1:0] e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check({tag, ".out_pc"}, out_pc, e);
            check({tag, ".out_valid"}, 32'(out_valid), 32'd1);
            if (exp_q.size() > 0) tick();
        end
    endtask

    initial begin
        // reset
        reset = 1'b0;
        tick();
        tick();
        check_reset_values("reset");
        reset = 1'b1;
        tick();

        // basic replay
        write_entry(32'h100, 32'h13, 1'b0);
        write_entry(32'h104, 32'h14, 1'b0);
        write_entry(32'h108, 32'h15, 1'b0);
        write_entry(32'h10C, 32'hFC000AE3, 1'b1);
        check("basic.active", 32'(active), 32'd1);
        check("basic.wr_ready", 32'(wr_ready), 32'd0);
        check("basic.instr0", out_instruction, 32'h13);
        exp_q = '{32'h100, 32'h104, 32'h108, 32'h10C, 32'h100, 32'h104};
        drain_replay("basic");
        check("basic.state", 32'(state), 32'd2);

        // stall: out_pc is 0x104 now; hold for 3 more cycles
        bubble_idex = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall.hold", out_pc, 32'h104);
        end
        bubble_idex = 1'b0;
        tick();
        check("stall.release", out_pc, 32'h108);
        check("stall.instr", out_instruction, 32'h15);

        // exit
        mispredict = 1'b1;
        tick();
        mispredict = 1'b0;
        check("exit.flush", 32'(flush), 32'd1);
        check("exit.new_pc", new_pc, 32'h110);
        check("exit.out_valid", 32'(out_valid), 32'd0);
        check("exit.active", 32'(active), 32'd1);
        check("exit.out_instr", out_instruction, 32'h13);
        tick();
        check("exit.idle_active", 32'(active), 32'd0);
        check("exit.idle_wr_ready", 32'(wr_ready), 32'd1);
        check("exit.idle_flush", 32'(flush), 32'd0);
        check("exit.idle_state", 32'(state), 32'd0);

        // overflow: 8 entries without wr_last
        for (int i = 0; i < 8; i++) begin
            write_entry(32'h300 + 32'(4 * i), 32'h1000 + 32'(i), 1'b0);
            check("ovf.active", 32'(active), 32'd0);
            check("ovf.pulse", 32'(overflow), (i == 7) ? 32'd1 : 32'd0);
        end
        check("ovf.state", 32'(state), 32'd0);
        tick();
        check("ovf.pulse_end", 32'(overflow), 32'd0);

        // 4-entry loop after overflow
        write_entry(32'h110, 32'h21, 1'b0);
        write_entry(32'h114, 32'h22, 1'b0);
        write_entry(32'h118, 32'h23, 1'b0);
        write_entry(32'h11C, 32'hFE000AE3, 1'b1);
        exp_q = '{32'h110, 32'h114, 32'h118, 32'h11C, 32'h110, 32'h114, 32'h118, 32'h11C};
        drain_replay("loop4");
        check("loop4.instr", out_instruction, 32'hFE000AE3);
        mispredict = 1'b1;
        tick();
        mispredict = 1'b0;
        check("loop4.flush", 32'(flush), 32'd1);
        check("loop4.new_pc", new_pc, 32'h120);
        tick();

        // mispredict during FILL
        write_entry(32'h400, 32'h31, 1'b0);
        write_entry(32'h404, 32'h32, 1'b0);
        check("fillmp.state_fill", 32'(state), 32'd1);
        mispredict = 1'b1;
        tick();
        mispredict = 1'b0;
        check("fillmp.state", 32'(state), 32'd0);
        check("fillmp.flush", 32'(flush), 32'd0);
        check("fillmp.active", 32'(active), 32'd0);
        tick();
        check("fillmp.flush_late", 32'(flush), 32'd0);

        // reset during REPLAY
        write_entry(32'h500, 32'h41, 1'b0);
        write_entry(32'h504, 32'h42, 1'b1);
        tick();
        check("rstrep.pc", out_pc, 32'h504);
        reset = 1'b0;
        tick();
        check_reset_values("rstrep");
        reset = 1'b1;
        tick();

        // single-entry loop; writes offered during replay must be ignored
        write_entry(32'h200, 32'hFE000EE3, 1'b1);
        wr_valid = 1'b1;
        wr_pc    = 32'hDEAD0000;
        wr_instr = 32'hBEEF;
        for (int i = 0; i < 4; i++) begin
            check("single.pc", out_pc, 32'h200);
            check("single.instr", out_instruction, 32'hFE000EE3);
            tick();
        end
        wr_valid = 1'b0;
        // mispredict together with a stall still exits
        bubble_idex = 1'b1;
        mispredict  = 1'b1;
        tick();
        bubble_idex = 1'b0;
        mispredict  = 1'b0;
        check("single.flush", 32'(flush), 32'd1);
        check("single.new_pc", new_pc, 32'h204);
        check("single.out_valid", 32'(out_valid), 32'd0);
        tick();
        check("single.idle", 32'(state), 32'd0);
        check("single.new_pc_clr", new_pc, 32'h0);

        // final report
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/loop_replay_reader.md
# loop_replay_reader

Read side of the loop buffer. The loop detector (writer) pushes the captured body of a short backward-branch loop, one (PC, instruction) entry per cycle. This block stores the body and replays it cyclically into the IF/ID boundary while the front end is blocked. On a loop-exit mispredict it stops replay, flushes, and redirects fetch to the fall-through PC.

## Interface
- DEPTH, 8, loop-body capacity in entries, power of two, ≥2
- XLEN, 32, PC and instruction width
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-low; all state clears on any edge where reset=0
- wr_valid  in  1  writer presents an entry
- wr_pc  in  XLEN  PC of the entry
- wr_instr  in  XLEN  instruction word
- wr_last  in  1  entry is the closing backward branch
- wr_ready  out  1  block accepts an entry this cycle
- bubble_idex  in  1  downstream stall; hold the current replay output
- mispredict  in  1  loop-exit branch resolved not-taken; terminate replay
- active  out  1  replay in progress; fetch must stay blocked
- out_valid  out  1  out_pc/out_instruction are meaningful
- out_pc  out  XLEN  PC of the replayed entry
- out_instruction  out  XLEN  replayed instruction word; NOP 32'h00000013 when out_valid=0
- flush  out  1  one-cycle pulse at replay exit
- new_pc  out  XLEN  redirect target, valid while flush=1, else 0
- overflow  out  1  one-cycle pulse when a fill is aborted because the loop is longer than DEPTH

## Operation
- States: IDLE, FILL, REPLAY, EXIT. Reset state is IDLE.
- Reset values: wr_ready=1, active=0, out_valid=0, out_pc=0, out_instruction=32'h00000013, flush=0, new_pc=0, overflow=0. Counters and pointers are 0.
- IDLE:
  - wr_ready=1.
  - An entry is accepted when wr_valid=1. It is written to slot 0 and wr_cnt becomes 1.
  - If that entry has wr_last=1, go to REPLAY; otherwise go to FILL.
- FILL:
  - wr_ready=1. Each accepted entry is written at wr_cnt, then wr_cnt increments.
  - Accepted entry with wr_last=1: store len=wr_cnt+1 and last_pc=wr_pc, then go to REPLAY.
  - Accepted entry with wr_last=0 when wr_cnt=DEPTH-1: discard the fill, pulse overflow, go to IDLE.
  - mispredict=1: discard the fill, go to IDLE, no flush.
- REPLAY:
  - wr_ready=0, active=1, out_valid=1.
  - Outputs show mem[rd_ptr].
  - rd_ptr advances each cycle where bubble_idex=0. It wraps from len-1 to 0.
  - bubble_idex=1 holds rd_ptr and the outputs.
- Exit from REPLAY: when mispredict=1, go to EXIT. This takes priority over bubble_idex.
- EXIT (one cycle):
  - flush=1, new_pc=last_pc+4 (mod 2^XLEN), active=1, out_valid=0.
  - Next state is IDLE.
- Writes while wr_ready=0 are ignored. The writer must hold wr_valid; no entry is lost.
- mispredict in IDLE or EXIT is ignored.

## Timing
- Write acceptance happens on the clock edge where wr_valid & wr_ready.
- The first replay output (slot 0, out_valid=1) appears the cycle after the wr_last entry is accepted.
- Steady replay: one entry per cycle. A loop of length L repeats every L cycles plus the number of stall cycles.
- mispredict sampled in cycle N:
  - cycle N+1: flush=1, out_valid=0.
  - cycle N+2: IDLE, active=0, wr_ready=1.
- Reset asserted mid-FILL or mid-REPLAY: outputs take their reset values on the next edge, and any pending flush is dropped.
- len=1 (the branch is its own loop): the same entry repeats every cycle.
- All outputs are registered.

## Structure
- Shared header loop_defs:
  - state encodings (IDLE=0, FILL=1, REPLAY=2, EXIT=3)
  - NOP_INSTR=32'h00000013
  - XLEN default
  - Used by both writer and reader.
- One sub-module, loop_body_mem:
  - DEPTH × (2·XLEN) register array
  - one synchronous write port, one asynchronous read port
  - no reset on contents
- Top level: FSM, wr_cnt, rd_ptr, len, last_pc, and output registers.

## Test plan
- Basic replay:
  - Stimulus: write (0x100,0x13), (0x104,0x14), (0x108,0x15), then (0x10C,0xFC000AE3) with wr_last=1.
  - Required response: out_pc sequence 0x100, 0x104, 0x108, 0x10C, 0x100, … starting the cycle after the last write; active=1.
- Exit:
  - Stimulus: basic replay, then mispredict=1 for one cycle.
  - Required response: the next cycle has flush=1, new_pc=0x110, out_valid=0; the following cycle has active=0, wr_ready=1.
- Stall:
  - Stimulus: during replay, bubble_idex=1 for 3 cycles while out_pc=0x104.
  - Required response: out_pc stays 0x104 for 4 cycles, then 0x108.
  - Also: mispredict together with bubble_idex still gives flush on the next cycle.
- Overflow (DEPTH=8):
  - Stimulus: 8 writes, none with wr_last.
  - Required response: one overflow pulse, state returns to IDLE, active never set.
  - Then a 4-entry loop at 0x110..0x11C replays correctly, and its exit gives new_pc=0x120.
- Mid-operation events:
  - Stimulus: mispredict during FILL.
  - Required response: return to IDLE, flush=0.
  - Stimulus: reset=0 during REPLAY.
  - Required response: next cycle all outputs at reset values, and out_instruction=0x13.
- Single-entry loop:
  - Stimulus: write (0x200, 0xFE000EE3) with wr_last=1.
  - Required response: out_pc=0x200 every cycle until mispredict, then new_pc=0x204.
